// File: rtl/ref_ram_arbiter_if.sv
// ref_ram_arbiter_if
//   Bundle between the reference-frame requesters, the reconstruction write
//   path and the single shared frame-memory port.
//   master : requester/memory side (drives requests, write data, mem_rdata)
//   slave  : arbiter side (drives grants, read return, memory command, busy)
//   Signals:
//     rd_req[3:0]  rd_addr[4*ADDR_W]  rd_gnt[3:0]  rd_valid[3:0]  rd_data
//     wr_req  wr_addr  wr_data  wr_gnt
//     mem_en  mem_we  mem_addr  mem_wdata  mem_rdata
//     busy
interface ref_ram_arbiter_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
);
  logic [3:0]          rd_req;
  logic [4*ADDR_W-1:0] rd_addr;
  logic [3:0]          rd_gnt;
  logic [3:0]          rd_valid;
  logic [DATA_W-1:0]   rd_data;

  logic                wr_req;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_gnt;

  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  logic                busy;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
    input  rd_gnt, rd_valid, rd_data, wr_gnt,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
    output rd_gnt, rd_valid, rd_data, wr_gnt,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/ref_ram_arbiter.sv
// ref_ram_arbiter
//   Arbitrates four reference-picture read requesters (L0/L1 luma/chroma) and
//   one reconstruction write requester onto a single frame-memory port.
//   Reads are fixed-length bursts granted round-robin; a write is one cycle
//   and alternates with reads when both keep requesting.
//   Ports:
//     clk      clock
//     reset_n  asynchronous active-low reset
//     bus      ref_ram_arbiter_if.slave (requests, grants, read return,
//              memory command port, busy)
//   Build option:
//     REF_ARB_L1_EN  defined   : all four read requesters arbitrate
//                    undefined : L1 requesters (bits 3:2) ignored, P-slice build
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | memory port idle, arbitrating every cycle
// RD_BURST | issuing read beats; arbitrates again on the last beat
// WR       | single write cycle on the memory port; arbitrates again
module ref_ram_arbiter #(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4,
  parameter int RD_LAT    = 2
) (
  input logic              clk,
  input logic              reset_n,
  ref_ram_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(BURST_LEN);

`ifdef REF_ARB_L1_EN
  localparam logic [3:0] RD_MASK = 4'b1111;
`else
  localparam logic [3:0] RD_MASK = 4'b0011;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR       = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  beat_left;
  logic [1:0]        last_gnt;
  logic              last_was_wr;
  logic [3:0]        owner;
  logic [3:0]        tag_pipe [RD_LAT];

  logic [3:0]        rd_gnt_q;
  logic              wr_gnt_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [ADDR_W-1:0] req_addr [4];
  logic [3:0]        req_eff;
  logic [1:0]        win_idx;
  logic [1:0]        probe;
  logic              win_found;
  logic              slot_free;
  logic              do_wr;
  logic              do_rd;
  logic              pipe_busy;
  logic [3:0]        rd_valid_w;

  for (genvar g = 0; g < 4; g++) begin : g_addr
    assign req_addr[g] = bus.rd_addr[g*ADDR_W +: ADDR_W];
  end

  assign req_eff = bus.rd_req & RD_MASK;

  // Round-robin: probe last_gnt+1, +2, +3, +4 (mod 4). With the L1 pair masked
  // off the same search naturally alternates between bits 0 and 1.
  always_comb begin
    win_idx   = 2'd0;
    win_found = 1'b0;
    probe     = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      probe = last_gnt + 2'(i);
      if (!win_found && req_eff[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
  end

  // A slot opens in IDLE, in WR, and on the last beat of a burst, so grants
  // chain with no dead cycle on mem_en.
  assign slot_free = (state != RD_BURST) || (beat_left == '0);
  // After a write, a pending read takes the next slot; this bounds write wait
  // to one burst and makes writes and bursts alternate under load.
  assign do_wr     = bus.wr_req && !(last_was_wr && (req_eff != 4'b0));
  assign do_rd     = !do_wr && win_found;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      beat_left   <= '0;
      last_gnt    <= 2'd3;
      last_was_wr <= 1'b0;
      owner       <= 4'b0;
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= 4'b0;
      rd_gnt_q    <= 4'b0;
      wr_gnt_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      rd_gnt_q <= 4'b0;
      wr_gnt_q <= 1'b0;

      // Owner tag follows each read beat so the returning word is steered to
      // the requester that issued it, RD_LAT cycles later.
      tag_pipe[0] <= (mem_en_q && !mem_we_q) ? owner : 4'b0;
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];

      if (!slot_free) begin
        beat_left  <= beat_left - CNT_W'(1);
        mem_addr_q <= mem_addr_q + ADDR_W'(1);
      end else if (do_wr) begin
        state       <= WR;
        beat_left   <= '0;
        last_was_wr <= 1'b1;
        wr_gnt_q    <= 1'b1;
        mem_en_q    <= 1'b1;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= bus.wr_addr;
        mem_wdata_q <= bus.wr_data;
      end else if (do_rd) begin
        state       <= RD_BURST;
        beat_left   <= CNT_W'(BURST_LEN - 1);
        last_gnt    <= win_idx;
        last_was_wr <= 1'b0;
        owner       <= 4'b0001 << win_idx;
        rd_gnt_q    <= 4'b0001 << win_idx;
        mem_en_q    <= 1'b1;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= req_addr[win_idx];
        mem_wdata_q <= '0;
      end else begin
        state       <= IDLE;
        beat_left   <= '0;
        mem_en_q    <= 1'b0;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= '0;
        mem_wdata_q <= '0;
      end
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) pipe_busy = pipe_busy | (tag_pipe[i] != 4'b0);
  end

  assign rd_valid_w    = tag_pipe[RD_LAT-1] & RD_MASK;

  assign bus.rd_gnt    = rd_gnt_q & RD_MASK;
  assign bus.rd_valid  = rd_valid_w;
  assign bus.rd_data   = (rd_valid_w != 4'b0) ? bus.mem_rdata : '0;
  assign bus.wr_gnt    = wr_gnt_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state != IDLE) || pipe_busy;

endmodule

// File: tb/tb_ref_ram_arbiter.sv
// tb_ref_ram_arbiter
//   Directed scenarios followed by random request traffic; every cycle the DUT
//   outputs are compared with a slot-level reference model. A synthetic ROM
//   (word = function of address) answers reads with RD_LAT cycles of latency.
module tb_ref_ram_arbiter;
  localparam int AW = 22;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam int RL = 2;
`ifdef REF_ARB_L1_EN
  localparam logic [3:0] RMASK = 4'hF;
  localparam int         NREQ  = 4;
`else
  localparam logic [3:0] RMASK = 4'h3;
  localparam int         NREQ  = 2;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ref_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ref_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .RD_LAT(RL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, 10'h2B5} ^ 32'h9E37_0000;
  endfunction

  // memory environment
  logic [DW-1:0] rpipe [RL];
  always @(posedge clk) begin
    rpipe[0] <= (bus.mem_en && !bus.mem_we) ? mem_word(bus.mem_addr) : '0;
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.mem_rdata = rpipe[RL-1];

  // stimulus state
  logic [3:0]    req_v = 4'b0;
  logic [AW-1:0] req_addr_v [4];
  logic          wr_req_v = 1'b0;
  logic [AW-1:0] wr_addr_v = '0;
  logic [DW-1:0] wr_data_v = '0;

  // reference model state
  typedef struct {
    int            due;
    logic [3:0]    who;
    logic [AW-1:0] addr;
  } ev_t;
  ev_t           evq[$];
  int            cyc = 0;
  int            m_left = 0;
  logic [AW-1:0] m_addr = '0;
  logic [3:0]    m_owner = 4'b0;
  int            m_last = 3;
  bit            m_prev_wr = 1'b0;

  logic [3:0]    e_rd_gnt, e_valid;
  logic          e_wr_gnt, e_en, e_we, e_busy;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  task automatic apply();
    bus.rd_req  = req_v;
    for (int i = 0; i < 4; i++) bus.rd_addr[i*AW +: AW] = req_addr_v[i];
    bus.wr_req  = wr_req_v;
    bus.wr_addr = wr_addr_v;
    bus.wr_data = wr_data_v;
  endtask

  // One memory-port slot per cycle: continue the burst, or pick write / read.
  task automatic model_edge();
    logic [3:0] eff;
    int         pick;
    int         r;
    e_rd_gnt = 4'b0; e_wr_gnt = 1'b0; e_en = 1'b0; e_we = 1'b0;
    e_addr = '0; e_wdata = '0; e_valid = 4'b0; e_rdata = '0; e_busy = 1'b0;
    if (!reset_n) begin
      m_left = 0; m_last = 3; m_prev_wr = 1'b0; evq.delete();
      return;
    end
    cyc++;
    eff = req_v & RMASK;
    if (m_left > 0) begin
      m_left--;
      m_addr++;
      e_en = 1'b1; e_addr = m_addr;
    end else if (wr_req_v && !(m_prev_wr && eff != 4'b0)) begin
      e_en = 1'b1; e_we = 1'b1; e_addr = wr_addr_v; e_wdata = wr_data_v;
      e_wr_gnt = 1'b1; m_prev_wr = 1'b1;
    end else if (eff != 4'b0) begin
      pick = -1;
      for (int k = 1; k <= 4; k++) begin
        r = (m_last + k) % 4;
        if (pick < 0 && eff[r]) pick = r;
      end
      m_last = pick; m_owner = 4'b0001 << pick; m_addr = req_addr_v[pick];
      m_left = BL - 1; m_prev_wr = 1'b0;
      e_en = 1'b1; e_addr = m_addr; e_rd_gnt = m_owner;
    end
    if (evq.size() > 0 && evq[0].due == cyc) begin
      e_valid = evq[0].who;
      e_rdata = mem_word(evq[0].addr);
      void'(evq.pop_front());
    end
    if (e_en && !e_we) evq.push_back('{cyc + RL, m_owner, e_addr});
    e_busy = e_en || (e_valid != 4'b0) || (evq.size() > 0 && evq[0].due < cyc + RL);
  endtask

  task automatic check_all();
    check("rd_gnt",    64'(bus.rd_gnt),    64'(e_rd_gnt));
    check("wr_gnt",    64'(bus.wr_gnt),    64'(e_wr_gnt));
    check("mem_en",    64'(bus.mem_en),    64'(e_en));
    check("mem_we",    64'(bus.mem_we),    64'(e_we));
    check("mem_addr",  64'(bus.mem_addr),  64'(e_addr));
    check("mem_wdata", 64'(bus.mem_wdata), 64'(e_wdata));
    check("rd_valid",  64'(bus.rd_valid),  64'(e_valid));
    check("rd_data",   64'(bus.rd_data),   64'(e_rdata));
    check("busy",      64'(bus.busy),      64'(e_busy));
  endtask

  task automatic step();
    apply();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    req_v = 4'b0; wr_req_v = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 22'h3FFFFF - AW'($urandom_range(0, 5));
    return AW'($urandom);
  endfunction

  logic [3:0]    exp4;
  logic [AW-1:0] expa;
  logic [AW-1:0] wrap_exp [4];

  initial begin
    for (int i = 0; i < 4; i++) req_addr_v[i] = AW'(i * 32'h1000);
    wrap_exp[0] = 22'h3FFFFE; wrap_exp[1] = 22'h3FFFFF;
    wrap_exp[2] = 22'h000000; wrap_exp[3] = 22'h000001;

    // reset state
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("rst_mem_en", 64'(bus.mem_en), 64'(0));
    check("rst_busy",   64'(bus.busy),   64'(0));
    reset_n = 1'b1;
    idle(2);

    // all four requesting: round-robin from bit 0, memory port never idle
    req_v = 4'hF;
    for (int c = 0; c < 5 * BL; c++) begin
      step();
      check("rr_mem_en", 64'(bus.mem_en), 64'(1));
      if (c % BL == 0) begin
        exp4 = 4'b0001 << ((c / BL) % NREQ);
        check("rr_order", 64'(bus.rd_gnt), 64'(exp4));
      end
    end
    idle(6);

    // single L0 luma burst at 0x100
    req_v = 4'b0001; req_addr_v[0] = 22'h100;
    for (int c = 0; c < 7; c++) begin
      step();
      req_v = 4'b0;
      exp4 = (c == 0) ? 4'b0001 : 4'b0000;
      check("burst_gnt", 64'(bus.rd_gnt), 64'(exp4));
      if (c < BL) begin
        expa = 22'h100 + AW'(c);
        check("burst_addr", 64'(bus.mem_addr), 64'(expa));
      end
      exp4 = (c >= RL && c < RL + BL) ? 4'b0001 : 4'b0000;
      check("burst_valid", 64'(bus.rd_valid), 64'(exp4));
    end
    idle(4);

    // address wrap at the top of memory
    req_v = 4'b0010; req_addr_v[1] = 22'h3FFFFE;
    for (int c = 0; c < BL; c++) begin
      step();
      req_v = 4'b0;
      check("wrap_addr", 64'(bus.mem_addr), 64'(wrap_exp[c]));
    end
    idle(6);

    // write and read rising together: write first, then the read
    wr_req_v = 1'b1; wr_addr_v = 22'h1234; wr_data_v = 32'hDEADBEEF;
    req_v = 4'b0010; req_addr_v[1] = 22'h2000;
    step();
    check("wr_first_gnt",  64'(bus.wr_gnt),   64'(1));
    check("wr_first_addr", 64'(bus.mem_addr), 64'(22'h1234));
    step();
    check("rd_after_wr", 64'(bus.rd_gnt), 64'(4'b0010));
    for (int c = 0; c < 14; c++) step();
    idle(6);

    // write arriving during beat 1 waits for the end of the burst
    req_v = 4'b0001; req_addr_v[0] = 22'h40;
    step();
    req_v = 4'b0;
    step();
    wr_req_v = 1'b1; wr_addr_v = 22'h77; wr_data_v = 32'h5555_AAAA;
    step();
    check("wr_wait_b2", 64'(bus.wr_gnt), 64'(0));
    step();
    check("wr_wait_b3", 64'(bus.wr_gnt), 64'(0));
    step();
    check("wr_after_burst", 64'(bus.wr_gnt), 64'(1));
    wr_req_v = 1'b0;
    idle(6);

    // reset in the middle of a burst
    req_v = 4'b0001; req_addr_v[0] = 22'h500;
    step();
    req_v = 4'b0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("async_rst_en",    64'(bus.mem_en),   64'(0));
    check("async_rst_valid", 64'(bus.rd_valid), 64'(0));
    check("async_rst_addr",  64'(bus.mem_addr), 64'(0));
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("no_valid_after_rst", 64'(bus.rd_valid), 64'(0));
    end

`ifndef REF_ARB_L1_EN
    req_v = 4'b1100;
    for (int c = 0; c < 6; c++) begin
      step();
      check("l1_ignored", 64'(bus.rd_gnt), 64'(0));
    end
    req_v = 4'b0;
`endif
    idle(4);

    // random traffic
    for (int c = 0; c < 2500; c++) begin
      reset_n = ($urandom_range(0, 399) != 0);
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (req_v[i]) begin
          if (e_rd_gnt[i]) begin
            if ($urandom_range(0, 1) == 0) req_v[i] = 1'b0;
            else req_addr_v[i] = rand_addr();
          end else if ($urandom_range(0, 49) == 0) begin
            req_v[i] = 1'b0;
          end
        end else if ($urandom_range(0, 5) == 0) begin
          req_v[i] = 1'b1;
          req_addr_v[i] = rand_addr();
        end
      end
      if (wr_req_v) begin
        if (e_wr_gnt) begin
          if ($urandom_range(0, 1) == 0) wr_req_v = 1'b0;
          wr_addr_v = rand_addr();
          wr_data_v = $urandom;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        wr_req_v = 1'b1;
        wr_addr_v = rand_addr();
        wr_data_v = $urandom;
      end
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
